// File: rtl/requant_pkg.sv
// Shared requantization types, widths and the rounding divide-by-power-of-two helper.
// Combinational only; no latency and no backpressure.
package requant_pkg;

    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 5;

    typedef struct packed {
        logic [SHIFT_W-1:0]      shift;
        logic signed [31:0]      offset;
        logic signed [OUT_W-1:0] act_min;
        logic signed [OUT_W-1:0] act_max;
    } elem_param_t;

    typedef struct packed {
        logic signed [31:0]      r1;
        logic signed [31:0]      offset;
        logic signed [OUT_W-1:0] act_min;
        logic signed [OUT_W-1:0] act_max;
    } stage1_t;

    // Round half away from zero: negative inputs need a strictly larger remainder to round up.
    function automatic logic signed [31:0] rdbpot(input logic signed [31:0] x,
                                                  input logic [SHIFT_W-1:0] sh);
        logic [31:0] mask;
        logic [31:0] rem;
        logic [31:0] thr;
        mask = (32'd1 << sh) - 32'd1;
        rem  = x & mask;
        thr  = (mask >> 1) + {31'd0, x[31]};
        return (x >>> sh) + ((rem > thr) ? 32'sd1 : 32'sd0);
    endfunction

endpackage

// File: rtl/requant_post_if.sv
// Stream bundle between the multiply stage, requant_post and the response path.
// Signals only; handshake semantics live in requant_post.
interface requant_post_if;
    import requant_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [31:0]      in_data;
    logic [SHIFT_W-1:0]      shift;
    logic signed [31:0]      offset;
    logic signed [OUT_W-1:0] act_min;
    logic signed [OUT_W-1:0] act_max;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_data;
    logic                    flush;

    modport slave (
        input  in_valid, in_data, shift, offset, act_min, act_max, out_ready, flush,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, shift, offset, act_min, act_max, out_ready, flush,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/requant_pack.sv
// Packs four int8 results little-endian per 32-bit word; acts as the second pipeline register.
// Latency 1 cycle from a stage-1 result; in_rdy = !out_vld | out_rdy, whole word holds while stalled.
`ifdef REQUANT_POST_PACK_EN
module requant_pack
    import requant_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_vld,
    input  logic [OUT_W-1:0] in_dat,
    output logic             in_rdy,
    input  logic             flush,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [31:0]      out_dat
);

    logic [1:0]  cnt;
    logic [31:0] word;
    logic [31:0] base;
    logic [31:0] nxt;
    logic [2:0]  fill;
    logic        emit;

    assign in_rdy  = !out_vld | out_rdy;
    assign out_dat = word;

    // A word being handed off this cycle is replaced by an empty one, so unfilled bytes stay 0.
    always_comb begin
        base = out_vld ? 32'd0 : word;
        nxt  = base;
        fill = {1'b0, cnt};
        if (in_vld) begin
            nxt  = base | (32'(in_dat) << {cnt, 3'b000});
            fill = fill + 3'd1;
        end
        emit = (fill == 3'd4) || (flush && (fill != 3'd0));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word    <= '0;
            cnt     <= '0;
            out_vld <= 1'b0;
        end else if (in_rdy) begin
            word    <= nxt;
            out_vld <= emit;
            cnt     <= emit ? 2'd0 : fill[1:0];
        end
    end

endmodule
`endif

// File: rtl/requant_post.sv
// Requant tail: rounding shift, zero-point add, clamp to int8; 2-cycle latency, 1/cycle.
// in_ready = !out_valid | out_ready, both stages freeze together. REQUANT_POST_PACK_EN packs 4 per word.
module requant_post
    import requant_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    requant_post_if.slave  bus
);

    elem_param_t             prm;
    stage1_t                 s1_q;
    logic                    s1_vld;
    logic                    en;
    logic signed [32:0]      sum;
    logic signed [32:0]      lo;
    logic signed [32:0]      hi;
    logic signed [OUT_W-1:0] res;

    assign prm = '{shift: bus.shift, offset: bus.offset,
                   act_min: bus.act_min, act_max: bus.act_max};
    assign bus.in_ready = en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
        end else if (en) begin
            s1_vld <= bus.in_valid;
            s1_q   <= '{r1: rdbpot(bus.in_data, prm.shift), offset: prm.offset,
                        act_min: prm.act_min, act_max: prm.act_max};
        end
    end

    // 33-bit sum so an extreme r1 plus offset saturates at the clamp instead of wrapping.
    always_comb begin
        sum = $signed({s1_q.r1[31], s1_q.r1}) + $signed({s1_q.offset[31], s1_q.offset});
        lo  = $signed({{(33-OUT_W){s1_q.act_min[OUT_W-1]}}, s1_q.act_min});
        hi  = $signed({{(33-OUT_W){s1_q.act_max[OUT_W-1]}}, s1_q.act_max});
        res = sum[OUT_W-1:0];
        if (sum < lo) begin
            res = s1_q.act_min;
        end else if (sum > hi) begin
            res = s1_q.act_max;
        end
    end

`ifdef REQUANT_POST_PACK_EN
    requant_pack u_pack (
        .clk     (clk),
        .reset_n (reset_n),
        .in_vld  (s1_vld),
        .in_dat  (res),
        .in_rdy  (en),
        .flush   (bus.flush),
        .out_vld (bus.out_valid),
        .out_rdy (bus.out_ready),
        .out_dat (bus.out_data)
    );
`else
    logic             s2_vld;
    logic [OUT_W-1:0] s2_q;
    logic             unused_flush;

    assign unused_flush  = bus.flush;
    assign en            = !s2_vld | bus.out_ready;
    assign bus.out_valid = s2_vld;
    assign bus.out_data  = {{(32-OUT_W){s2_q[OUT_W-1]}}, s2_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_vld <= 1'b0;
            s2_q   <= '0;
        end else if (en) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_q <= res;
            end
        end
    end
`endif

endmodule

// File: doc/requant_post.md
# requant_post

Requantization tail stage that consumes the 32-bit result of the saturating rounding doubling high multiply and produces a clamped int8 activation. It applies a rounding divide by power of two, adds the output zero-point offset and clamps to the activation range, all in a two-register pipeline with valid/ready flow control. It sits between the fixed-point multiply stage and the CFU response path.

## Interface
- OUT_W, 8, output element width in bits.
- SHIFT_W, 5, width of the right-shift amount (shift range 0..31).
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/shift/offset/act_min/act_max are valid this cycle.
- in_ready  output  1  stage accepts input this cycle.
- in_data  input  32  signed multiply-stage result.
- shift  input  SHIFT_W  right-shift amount, sampled with in_data.
- offset  input  32  signed output zero-point, sampled with in_data.
- act_min  input  OUT_W  signed lower clamp, sampled with in_data.
- act_max  input  OUT_W  signed upper clamp, sampled with in_data; act_min <= act_max is required of the producer.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  32  result (see Configuration).
- flush  input  1  emit a partial packed word (packing build only; ignored otherwise).

## Operation
- Stage 1 (RDBPOT): mask = (1<<shift)-1; rem = in_data & mask; thr = (mask>>1) + (in_data<0); r1 = (in_data >>> shift) + (rem > thr). Round-half-away-from-zero. Register r1, act_min, act_max, and offset.
- Stage 2: sum = sext33(r1) + sext33(offset), 33-bit, no wrap; clamp to [act_min, act_max]; register the low OUT_W bits.
- Handshake: en = !out_valid | out_ready; in_ready = en (combinational from out_ready). When en=0, both stages hold. A transfer occurs on in_valid & in_ready and on out_valid & out_ready.
- Each stage carries a valid bit; bubbles propagate normally, and no data is dropped or duplicated.

## Timing
- Reset: all valid bits 0, out_valid=0, out_data=0, pack counter 0, in_ready=1.
- Latency: 2 cycles from the input handshake to out_valid with out_ready held high; throughput is 1 per cycle.
- Stall: out_ready low with out_valid high freezes the pipeline; out_data is stable until accepted.
- Reset asserted mid-operation: in-flight results are discarded immediately and asynchronously; the first input after reset_n deasserts follows normal latency.
- shift=0: rem=0, so the result is in_data unchanged.
- shift=31: this is a legal boundary case, with no special handling.

## Configuration
- REQUANT_POST_PACK_EN defined: results are packed four per word, little-endian (first result in [7:0]).
  - out_valid rises only when the 4th byte is written, or on flush with a count of 1..3.
  - Unfilled bytes are 0, and the counter returns to 0 after each emitted word.
  - flush with count 0 emits nothing.
  - If flush coincides with a stage-2 result, that result is included before the word is emitted.
  - Latency to out_valid is 2 cycles after the 4th input.
- Undefined: each result is emitted sign-extended to 32 bits, and flush is unused.

## Structure
- Shared package requant_pkg:
  - OUT_W and SHIFT_W defaults.
  - A struct for the per-element parameters (shift, offset, act_min, act_max).
  - A function rdbpot(x, shift) for reuse by the bench model.
- Sub-module requant_pack: the byte packer with its 2-bit counter and its own valid/ready. It is instantiated only under REQUANT_POST_PACK_EN.

## Test plan
- Positive half rounding: in_data=102, shift=2, offset=0, range [-128,127] -> out_data=26 (0x0000001A) two cycles later.
- Negative rounding:
  - in_data=-102, shift=2 -> -26.
  - in_data=-101, shift=2 -> -25 (0xFFFFFFE7).
- Offset and clamp:
  - in_data=1000, shift=0, offset=-128 -> 127.
  - in_data=0x80000000, shift=0, offset=-128 -> -128 (33-bit sum, no wrap).
  - in_data=5, offset=3, range [0,6] -> 6.
- Boundary shift: in_data=0x7FFFFFFF, shift=31 -> 1; in_data=7, shift=0 -> 7.
- Backpressure:
  - Offer 5 back-to-back inputs with out_ready low for 6 cycles: in_ready drops once both stages are full.
  - All 5 results then emerge in order and unchanged.
  - Pulse reset_n low mid-stream: out_valid goes to 0 immediately and no stale results appear afterwards.
- Packing (macro defined):
  - Results 1,2,3,4 -> single word 0x04030201.
  - Then results 5,-1 followed by flush -> 0x0000FF05.
  - flush with count 0 -> no out_valid.
